// File: rtl/stack_bus_downstream_arbiter_if.sv
// Manager-array to stack-bus handshake bundle for stack_bus_downstream_arbiter.
// master = requester/stack-bus side, slave = arbiter.
interface stack_bus_downstream_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 64,
    parameter int DEST_W   = 6,
    parameter int REQ_ID_W = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_sop;
    logic [NUM_REQ-1:0]        req_eop;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*DEST_W-1:0] req_dest;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      bus_valid;
    logic                      bus_sop;
    logic                      bus_eop;
    logic [DATA_W-1:0]         bus_data;
    logic [DEST_W-1:0]         bus_dest;
    logic [REQ_ID_W-1:0]       bus_src;
    logic                      bus_ready;
    logic                      err_nosop;
    logic                      err_overlen;

    modport master (
        output req_valid, req_sop, req_eop, req_data, req_dest, bus_ready,
        input  req_ready, bus_valid, bus_sop, bus_eop, bus_data, bus_dest, bus_src,
               err_nosop, err_overlen
    );
    modport slave (
        input  req_valid, req_sop, req_eop, req_data, req_dest, bus_ready,
        output req_ready, bus_valid, bus_sop, bus_eop, bus_data, bus_dest, bus_src,
               err_nosop, err_overlen
    );
endinterface

// File: rtl/stack_bus_downstream_arbiter.sv
// Round-robin packet arbiter onto the downstream stack bus with registered output stage.
// Optional macro STACK_BUS_DS_ARB_STATS_EN adds per-requester completed-packet counters.
module stack_bus_downstream_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 64,
    parameter int DEST_W    = 6,
    parameter int MAX_BEATS = 32,
    parameter int REQ_ID_W  = 2
) (
    input logic clk,
    input logic reset_poweron,
    stack_bus_downstream_arbiter_if.slave bif
`ifdef STACK_BUS_DS_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] stat_pkt_cnt
`endif
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [REQ_ID_W-1:0] grant_q, grant_d;
    logic [REQ_ID_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [DEST_W-1:0]   dest_lat_q, dest_lat_d;
    logic                bus_valid_q, bus_valid_d;
    logic                bus_sop_q, bus_sop_d;
    logic                bus_eop_q, bus_eop_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [DEST_W-1:0]   bus_dest_q, bus_dest_d;
    logic [REQ_ID_W-1:0] bus_src_q, bus_src_d;
    logic                err_nosop_q, err_nosop_d;
    logic                err_overlen_q, err_overlen_d;

    logic [NUM_REQ-1:0]  req_ready;
    logic [REQ_ID_W-1:0] winner;
    logic                found;
    logic                slot_free, g_valid, g_eop, accept, at_max;
    logic [DATA_W-1:0]   g_data;
    logic [CNT_W-1:0]    cnt_inc;

    assign slot_free = !bus_valid_q || bif.bus_ready;
    assign g_valid   = bif.req_valid[grant_q];
    assign g_eop     = bif.req_eop[grant_q];
    assign g_data    = bif.req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign accept    = (state_q == XFER) && g_valid && slot_free;
    assign cnt_inc   = beat_cnt_q + 1'b1;
    assign at_max    = (cnt_inc == CNT_W'(MAX_BEATS));

    // Round-robin search begins one past the last completed grant.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && bif.req_valid[(int'(last_grant_q) + i) % NUM_REQ]
                       && bif.req_sop[(int'(last_grant_q) + i) % NUM_REQ]) begin
                found  = 1'b1;
                winner = REQ_ID_W'((int'(last_grant_q) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= REQ_ID_W'(NUM_REQ - 1);
            beat_cnt_q    <= '0;
            dest_lat_q    <= '0;
            bus_valid_q   <= 1'b0;
            bus_sop_q     <= 1'b0;
            bus_eop_q     <= 1'b0;
            bus_data_q    <= '0;
            bus_dest_q    <= '0;
            bus_src_q     <= '0;
            err_nosop_q   <= 1'b0;
            err_overlen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
            dest_lat_q    <= dest_lat_d;
            bus_valid_q   <= bus_valid_d;
            bus_sop_q     <= bus_sop_d;
            bus_eop_q     <= bus_eop_d;
            bus_data_q    <= bus_data_d;
            bus_dest_q    <= bus_dest_d;
            bus_src_q     <= bus_src_d;
            err_nosop_q   <= err_nosop_d;
            err_overlen_q <= err_overlen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        dest_lat_d   = dest_lat_q;
        case (state_q)
            IDLE: begin
                // Destination is staged here so a still-pending last beat keeps its bus_dest.
                if (found) begin
                    state_d    = XFER;
                    grant_d    = winner;
                    dest_lat_d = bif.req_dest[int'(winner)*DEST_W +: DEST_W];
                end
            end
            XFER: begin
                if (accept) begin
                    beat_cnt_d = cnt_inc;
                    if (g_eop) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                    end else if (at_max) begin
                        state_d    = DRAIN;
                        beat_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (g_valid && g_eop) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        bus_valid_d   = bus_valid_q && !bif.bus_ready;
        bus_sop_d     = bus_sop_q;
        bus_eop_d     = bus_eop_q;
        bus_data_d    = bus_data_q;
        bus_dest_d    = bus_dest_q;
        bus_src_d     = bus_src_q;
        err_nosop_d   = 1'b0;
        err_overlen_d = err_overlen_q;
        case (state_q)
            IDLE: begin
                req_ready   = bif.req_valid & ~bif.req_sop;
                err_nosop_d = |(bif.req_valid & ~bif.req_sop);
            end
            XFER:    req_ready[grant_q] = slot_free;
            DRAIN:   req_ready[grant_q] = 1'b1;
            default: req_ready = '0;
        endcase
        if (accept) begin
            bus_valid_d = 1'b1;
            bus_sop_d   = (beat_cnt_q == '0);
            bus_eop_d   = g_eop || at_max;
            bus_data_d  = g_data;
            bus_dest_d  = dest_lat_q;
            bus_src_d   = grant_q;
            if (at_max && !g_eop) err_overlen_d = 1'b1;
        end
    end

    assign bif.req_ready   = req_ready & {NUM_REQ{reset_poweron}};
    assign bif.bus_valid   = bus_valid_q;
    assign bif.bus_sop     = bus_sop_q;
    assign bif.bus_eop     = bus_eop_q;
    assign bif.bus_data    = bus_data_q;
    assign bif.bus_dest    = bus_dest_q;
    assign bif.bus_src     = bus_src_q;
    assign bif.err_nosop   = err_nosop_q;
    assign bif.err_overlen = err_overlen_q;

`ifdef STACK_BUS_DS_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat_q, stat_d;
    logic                     pkt_done;

    assign pkt_done = accept && (g_eop || at_max);

    always_comb begin
        stat_d = stat_q;
        if (pkt_done) stat_d[grant_q] = stat_q[grant_q] + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) stat_q <= '0;
        else                stat_q <= stat_d;
    end

    assign stat_pkt_cnt = stat_q;
`endif
endmodule

// File: tb/tb_stack_bus_downstream_arbiter.sv
// Bench for stack_bus_downstream_arbiter: vector table, hand sequences, and a
// packet-level round-robin reference model under random stimulus.
`timescale 1ns/1ps
module tb_stack_bus_downstream_arbiter;
    localparam int NR = 4, DW = 64, DSW = 6, MB = 32, IW = 2;

    logic clk = 1'b0;
    logic reset_poweron = 1'b0;
    always #5 clk = ~clk;

    stack_bus_downstream_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .DEST_W(DSW), .REQ_ID_W(IW)) bif();
`ifdef STACK_BUS_DS_ARB_STATS_EN
    logic [NR*16-1:0] stat_pkt_cnt;
`endif

    stack_bus_downstream_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DEST_W(DSW), .MAX_BEATS(MB), .REQ_ID_W(IW)) dut (
        .clk(clk),
        .reset_poweron(reset_poweron),
        .bif(bif)
`ifdef STACK_BUS_DS_ARB_STATS_EN
        ,
        .stat_pkt_cnt(stat_pkt_cnt)
`endif
    );

    typedef struct {
        logic [3:0] v, s, e;
        logic       br;
        logic [3:0] x_rdy;
        logic       x_bv, x_sop, x_eop;
        logic [1:0] x_src;
        logic [5:0] x_dest;
        logic       x_nosop;
    } vec_t;

    typedef struct {
        logic [DW-1:0]  data;
        logic           sop, eop;
        logic [DSW-1:0] dest;
    } beat_t;

    typedef struct {
        logic [DW-1:0]  data;
        logic           sop, eop;
        logic [IW-1:0]  src;
        logic [DSW-1:0] dest;
    } obs_t;

    int    n_chk = 0, n_pass = 0;
    vec_t  tbl[14];
    beat_t rq[NR][$];
    obs_t  exp_q[$];
    logic  exp_ovl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic clr_in();
        bif.req_valid = '0; bif.req_sop = '0; bif.req_eop = '0;
        bif.req_data = '0; bif.req_dest = '0; bif.bus_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset_poweron = 1'b0;
        clr_in();
        for (int i = 0; i < NR; i++) rq[i].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_poweron = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic add_pkt(input int r, input int len, input logic [DSW-1:0] dst);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = {$urandom, $urandom};
            b.sop  = (j == 0);
            b.eop  = (j == len - 1);
            b.dest = dst;
            rq[r].push_back(b);
        end
    endtask

    // Expected bus stream: whole packets in round-robin order, truncated at MB beats.
    task automatic build_exp();
        beat_t cq[NR][$];
        beat_t b;
        obs_t  o;
        int    last, pick, j;
        for (int i = 0; i < NR; i++) cq[i] = rq[i];
        exp_q.delete();
        exp_ovl = 1'b0;
        last = NR - 1;
        forever begin
            pick = -1;
            for (int k = 1; k <= NR; k++)
                if (pick < 0 && cq[(last + k) % NR].size() > 0) pick = (last + k) % NR;
            if (pick < 0) break;
            j = 0;
            do begin
                b = cq[pick].pop_front();
                j++;
                if (j <= MB) begin
                    o.data = b.data; o.sop = (j == 1); o.eop = b.eop || (j == MB);
                    o.src = IW'(pick); o.dest = b.dest;
                    exp_q.push_back(o);
                end
                if (j == MB && !b.eop) exp_ovl = 1'b1;
            end while (!b.eop);
            last = pick;
        end
    endtask

    // mode: 0 bus_ready=1, 1 pattern 1,0,0,1, 2 random bus_ready and mid-packet valid gaps
    task automatic run_pkts(input int mode);
        int            cyc;
        int            left;
        logic [NR-1:0] acc;
        logic          pend, br, nosop_seen;
        obs_t          cur, ex;
        build_exp();
        cyc = 0;
        nosop_seen = 1'b0;
        left = 0;
        for (int i = 0; i < NR; i++) left += rq[i].size();
        while ((left > 0 || exp_q.size() > 0 || bif.bus_valid) && cyc < 4000) begin
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0) begin
                    bif.req_valid[i] = rq[i][0].sop ? 1'b1 : (mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1);
                    bif.req_sop[i]   = rq[i][0].sop;
                    bif.req_eop[i]   = rq[i][0].eop;
                    bif.req_data[i*DW +: DW]   = rq[i][0].data;
                    bif.req_dest[i*DSW +: DSW] = rq[i][0].dest;
                end else begin
                    bif.req_valid[i] = 1'b0; bif.req_sop[i] = 1'b0; bif.req_eop[i] = 1'b0;
                end
            end
            bif.bus_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3))
                                                            : 1'($urandom_range(0, 1));
            #1;
            acc  = bif.req_valid & bif.req_ready;
            pend = bif.bus_valid;
            br   = bif.bus_ready;
            cur.data = bif.bus_data; cur.sop = bif.bus_sop; cur.eop = bif.bus_eop;
            cur.src = bif.bus_src; cur.dest = bif.bus_dest;
            if (bif.err_nosop) nosop_seen = 1'b1;
            if (pend) begin
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    ex = br ? exp_q.pop_front() : exp_q[0];
                    chk("beat_data", cur.data, ex.data);
                    chk("beat_ctl", {cur.sop, cur.eop, cur.src, cur.dest}, {ex.sop, ex.eop, ex.src, ex.dest});
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) if (acc[i]) void'(rq[i].pop_front());
            left = 0;
            for (int i = 0; i < NR; i++) left += rq[i].size();
            cyc++;
        end
        chk("run_timeout", 64'(cyc >= 4000), 0);
        chk("run_missing", 64'(exp_q.size()), 0);
        chk("run_overlen", bif.err_overlen, exp_ovl);
        chk("run_nosop_quiet", nosop_seen, 0);
        clr_in();
    endtask

    initial begin
        int got;

        // reset state, with a non-sop head present that must not be acknowledged
        clr_in();
        bif.req_valid = 4'b1000;
        #12;
        chk("rst_bus_valid", bif.bus_valid, 0);
        chk("rst_bus_fields", {bif.bus_sop, bif.bus_eop, bif.bus_src, bif.bus_dest}, 0);
        chk("rst_bus_data", bif.bus_data, 0);
        chk("rst_req_ready", bif.req_ready, 0);
        chk("rst_errs", {bif.err_nosop, bif.err_overlen}, 0);
        clr_in();
        @(negedge clk);
        reset_poweron = 1'b1;
        @(posedge clk); #1;

        tbl[0]  = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2, 6'd5, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 6'd5, 1'b0};
        tbl[3]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 6'd5, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        tbl[5]  = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        tbl[7]  = '{4'b1001, 4'b0001, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1};
        tbl[8]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 6'd3, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        tbl[10] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};
        tbl[11] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 6'd4, 1'b0};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 6'd4, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0};

        for (int i = 0; i < NR; i++) bif.req_dest[i*DSW +: DSW] = DSW'(i + 3);
        for (int k = 0; k < 14; k++) begin
            bif.req_valid = tbl[k].v; bif.req_sop = tbl[k].s; bif.req_eop = tbl[k].e;
            bif.bus_ready = tbl[k].br;
            for (int i = 0; i < NR; i++) bif.req_data[i*DW +: DW] = DW'(k * 16 + i);
            #1;
            chk($sformatf("tbl%0d_ready", k), bif.req_ready, tbl[k].x_rdy);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", k), bif.bus_valid, tbl[k].x_bv);
            if (tbl[k].x_bv)
                chk($sformatf("tbl%0d_ctl", k), {bif.bus_sop, bif.bus_eop, bif.bus_src, bif.bus_dest},
                    {tbl[k].x_sop, tbl[k].x_eop, tbl[k].x_src, tbl[k].x_dest});
            chk($sformatf("tbl%0d_nosop", k), bif.err_nosop, tbl[k].x_nosop);
        end

        // all requesters hold single-beat packets: grants rotate 0,1,2,3,0,...
        do_reset();
        bif.req_valid = '1; bif.req_sop = '1; bif.req_eop = '1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(posedge clk); #1;
            if (bif.bus_valid) begin
                chk("rr_src", bif.bus_src, 64'(got % NR));
                got++;
            end
        end
        chk("rr_count", 64'(got), 8);
        clr_in();

        // req 2, 3 beats, dest 5, bus_ready held high
        do_reset();
        add_pkt(2, 3, 6'd5);
        run_pkts(0);

        // req 1, 4 beats, bus_ready toggling 1,0,0,1
        do_reset();
        add_pkt(1, 4, 6'd9);
        run_pkts(1);

        // req 0, 40 beats: 32 forwarded with forced eop, 8 dropped
        do_reset();
        add_pkt(0, 40, 6'd17);
        run_pkts(0);
        chk("ovl_sticky", bif.err_overlen, 1);

        // exactly MAX_BEATS beats with a real eop is not an overlength packet
        do_reset();
        add_pkt(3, MB, 6'd2);
        run_pkts(0);

        // reset during beat 2 of a 5-beat packet from req 2
        do_reset();
        for (int i = 0; i < NR; i++) bif.req_dest[i*DSW +: DSW] = DSW'(i + 3);
        bif.req_valid = 4'b0100; bif.req_sop = 4'b0100;
        repeat (2) begin @(posedge clk); #1; end
        bif.req_sop = '0;
        @(posedge clk); #1;
        chk("mid_valid_before", bif.bus_valid, 1);
        reset_poweron = 1'b0;
        #1;
        chk("mid_valid_async", bif.bus_valid, 0);
        chk("mid_fields_async", {bif.bus_eop, bif.bus_dest, bif.bus_src}, 0);
        clr_in();
        @(negedge clk);
        reset_poweron = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 4'b0101; bif.req_sop = 4'b0101; bif.req_eop = 4'b0101;
        for (int i = 0; i < NR; i++) bif.req_dest[i*DSW +: DSW] = DSW'(i + 3);
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_after_valid", bif.bus_valid, 1);
        chk("mid_after_src", {bif.bus_sop, bif.bus_eop, bif.bus_src, bif.bus_dest}, {1'b1, 1'b1, 2'd0, 6'd3});
        clr_in();

        // randomized multi-requester traffic against the packet model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NR; i++)
                for (int p = 0; p < int'($urandom_range(1, 4)); p++)
                    add_pkt(i, ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 40))
                                                           : int'($urandom_range(1, 6)),
                            DSW'($urandom));
            run_pkts(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stack_bus_downstream_arbiter.md
Name: stack_bus_downstream_arbiter

Overview:
Shares the single downstream stack bus between the NUM_REQ managers of the manager array. Requesters present packets as beats with start/end markers. The arbiter grants one packet at a time in round-robin order and forwards it through a registered output stage to the stack bus PE side. It also enforces a maximum packet length and flags protocol errors.

Parameters:
NUM_REQ, 4, number of manager requesters (2..16)
DATA_W, 64, downstream beat width
DEST_W, 6, PE destination id width
MAX_BEATS, 32, maximum beats per packet before forced termination
REQ_ID_W, 2, width of source id (clog2 of NUM_REQ, minimum 1)

Ports:
clk  in  1  system clock
reset_poweron  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_sop  in  NUM_REQ  per-requester start-of-packet
req_eop  in  NUM_REQ  per-requester end-of-packet
req_data  in  NUM_REQ*DATA_W  flattened beats; requester i at [i*DATA_W +: DATA_W]
req_dest  in  NUM_REQ*DEST_W  flattened destination PE id, sampled on sop beat
req_ready  out  NUM_REQ  per-requester beat accept
bus_valid  out  1  downstream beat valid
bus_sop  out  1  start-of-packet
bus_eop  out  1  end-of-packet
bus_data  out  DATA_W  beat data
bus_dest  out  DEST_W  destination, held for whole packet
bus_src  out  REQ_ID_W  granted requester id
bus_ready  in  1  stack bus accept
err_nosop  out  1  one-cycle pulse: non-sop beat discarded while idle
err_overlen  out  1  sticky: packet truncated at MAX_BEATS; cleared only by reset

Behaviour:
- Reset (reset_poweron low, async): state=IDLE; all bus_* outputs 0; req_ready=0; err_nosop=0; err_overlen=0; last_grant=NUM_REQ-1; beat_cnt=0.
- Handshake: a beat transfers when valid&ready. An output beat is accepted when bus_valid&bus_ready. bus_* registered: once bus_valid=1, bus_* are stable until accepted. Output slot free = !bus_valid | bus_ready.
- States:
  - IDLE: candidates = req_valid & req_sop. Round-robin search starts at last_grant+1 and wraps modulo NUM_REQ. If a candidate exists: grant<=winner, latch bus_dest from winner's req_dest, go to XFER next cycle; no beat accepted in the arbitration cycle.
  - IDLE, non-sop heads: requesters with req_valid&!req_sop get req_ready=1 and the beat is dropped; err_nosop pulses. This applies simultaneously with arbitration of other requesters.
  - XFER: req_ready[grant] = slot free; all other req_ready=0. Each accepted beat loads bus_data, bus_sop (first beat only), bus_eop=req_eop, bus_src=grant, bus_valid=1; beat_cnt increments.
  - XFER, normal end: accepted beat with eop -> last_grant<=grant, beat_cnt<=0, state=IDLE.
  - XFER, over-length: accepted beat that makes beat_cnt==MAX_BEATS without eop -> forced bus_eop=1, err_overlen<=1, state=DRAIN.
  - DRAIN: req_ready[grant]=1; beats are dropped, nothing is forwarded. On a dropped eop beat -> last_grant<=grant, state=IDLE.
- A sop beat seen in XFER is forwarded as data. bus_sop is driven only on the first beat.
- Latency: 1 arbitration cycle plus 1 register cycle from first sop to bus_valid. Throughput is 1 beat/cycle in XFER while bus_ready=1.
- bus_valid falls the cycle after the last beat is accepted, unless a new beat is loaded. Packets from consecutive grants are separated by at least one IDLE cycle.
- Single-beat packet (sop&eop): XFER for one beat, then IDLE.
- bus_ready low for an arbitrary time: the beat is held and req_ready[grant]=0. No data loss, no duplication.
- Reset mid-packet: everything returns to reset values. The partial packet is abandoned, and no eop is generated.

Optional Feature:
STACK_BUS_DS_ARB_STATS_EN
- Defined: adds output stat_pkt_cnt, width NUM_REQ*16. Each 16-bit counter increments when a packet from that requester completes (normal eop or forced eop) and wraps 0xFFFF->0. Counters reset to 0.
- Undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then req 2 sends a 3-beat packet, dest=5, bus_ready=1 -> bus shows sop on beat0, eop on beat2, bus_src=2, bus_dest=5; bus_valid first high 2 cycles after req_valid.
- All 4 requesters hold 1-beat packets continuously after reset -> grant order 0,1,2,3,0 with no requester granted twice in a row.
- Req 1 sends 4 beats while bus_ready toggles 1,0,0,1,… -> 4 beats delivered in order, each held stable while bus_ready=0, no duplicates.
- MAX_BEATS=32, req 0 sends 40 beats with eop on beat 39 -> 32 beats forwarded with eop on the 32nd, err_overlen=1, 8 beats dropped, then IDLE.
- Req 3 presents a non-sop beat in IDLE -> req_ready[3]=1 for that beat, err_nosop one-cycle pulse, nothing on bus.
- Reset asserted during beat 2 of a 5-beat packet -> bus_valid=0 asynchronously; after release, the next sop packet arbitrates normally starting from requester 0.
